isa_tx_sequencer: RTL and testbench
===================================

ISA_TX_SEQUENCER -- requirements
Module: isa_tx_sequencer

Interface
REQ-001 SHALL have parameter GUARD_CYCLES, default 3: idle cycles inserted after a frame whose address is in the UART region.
REQ-002 SHALL have parameter SYNC_BYTE, default 8'hA5: first byte of every frame.
REQ-003 SHALL have parameter DROP_ZERO_MASK, default 1: when 1, entries with mask 4'h0 are discarded without a frame.
REQ-004 SHALL have ports, in this order:
- clk_rd  in  1  sole clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  permits new fetches.
- isa_empty_i  in  1  capture FIFO empty.
- isa_rd_en_o  out  1  capture FIFO read strobe.
- isa_valid_i  in  1  capture FIFO dout valid.
- isa_addr_i  in  32  captured address.
- isa_data_i  in  32  captured data.
- isa_mask_i  in  4  captured byte mask.
- tx_data_o  out  8  byte to UART transmitter.
- tx_valid_o  out  1  tx_data_o valid.
- tx_ready_i  in  1  transmitter accepts byte.
- busy_o  out  1  state is not IDLE.
- frame_cnt_o  out  16  frames fully sent.
- drop_cnt_o  out  16  entries discarded.
- err_timeout_o  out  1  sticky fetch-timeout flag.

Function
REQ-005 SHALL implement states IDLE, FETCH, WAIT_VLD, SEND, GUARD; all outputs registered.
REQ-006 IDLE -> FETCH when enable=1 and isa_empty_i=0; otherwise SHALL remain in IDLE.
REQ-007 isa_rd_en_o SHALL be 1 for exactly one cycle, the FETCH cycle; FETCH -> WAIT_VLD unconditionally.
REQ-008 In WAIT_VLD, on isa_valid_i=1, SHALL latch addr/data/mask in that same cycle; isa_valid_i outside WAIT_VLD SHALL be ignored.
REQ-009 If isa_valid_i is not seen within 4 cycles of entering WAIT_VLD, SHALL set err_timeout_o (sticky until reset) and go to IDLE.
REQ-010 Latched entry with mask 4'h0 and DROP_ZERO_MASK=1 SHALL increment drop_cnt_o and go to IDLE; otherwise SHALL go to SEND with byte index 0.
REQ-011 A frame SHALL be 11 bytes: SYNC_BYTE; addr[31:24], [23:16], [15:8], [7:0]; data[31:24], [23:16], [15:8], [7:0]; {4'h0, mask}; checksum.
REQ-012 Checksum SHALL be the XOR of bytes 1 through 9 (sync excluded).
REQ-013 In SEND, tx_valid_o SHALL be 1 and tx_data_o SHALL hold the current byte stable until tx_valid_o && tx_ready_i; the index advances on each such cycle.
REQ-014 Byte k+1 SHALL be presented the cycle after byte k is accepted; with tx_ready_i held at 1, a frame occupies exactly 11 consecutive cycles.
REQ-015 On acceptance of byte 10, frame_cnt_o SHALL increment and tx_valid_o SHALL drop the next cycle.
REQ-016 The UART region SHALL be addr == 32'h40001000 or addr[31:12] == 20'h40004.
REQ-017 After the last byte, a UART-region frame SHALL go to GUARD when GUARD_CYCLES > 0; otherwise the next state SHALL be IDLE.
REQ-018 GUARD SHALL last exactly GUARD_CYCLES cycles, then go to IDLE.
REQ-019 enable=0 SHALL block only IDLE -> FETCH; a fetch or frame in progress SHALL complete.
REQ-020 frame_cnt_o and drop_cnt_o SHALL wrap from 16'hFFFF to 16'h0000 with no flag.
REQ-021 busy_o SHALL be 1 in every state except IDLE.

Reset
REQ-022 When rst=1 at a clk_rd edge, the block SHALL enter IDLE; isa_rd_en_o, tx_valid_o and err_timeout_o SHALL be 0; tx_data_o SHALL be 8'h00; both counters SHALL be 0; byte index and guard counter SHALL be cleared.
REQ-023 Reset asserted mid-frame SHALL abort the frame with no further bytes and no counter update; tx_valid_o SHALL be 0 in the cycle after the reset edge.

Verification
REQ-024 Fetch and frame: isa_empty_i falls; isa_valid_i is 1 the cycle after isa_rd_en_o; addr 0x00001000, data 0x12345678, mask 0xF; tx_ready_i held at 1 -> bytes A5 00 00 10 00 12 34 56 78 0F 17 on 11 consecutive cycles; frame_cnt_o = 1.
REQ-025 Backpressure: same entry; tx_ready_i is 0 for 5 cycles at byte 4 -> tx_data_o holds 0x00 at index 4 throughout; no byte lost or duplicated.
REQ-026 Drop: mask 0x0, DROP_ZERO_MASK=1 -> no tx_valid_o; drop_cnt_o = 1; state returns to IDLE.
REQ-027 Guard: addr 0x40004010 frame, FIFO non-empty afterwards -> exactly 3 cycles between the last-byte acceptance and the next isa_rd_en_o beyond the normal IDLE/FETCH path.
REQ-028 Timeout: isa_valid_i is never asserted after a fetch -> err_timeout_o = 1 within 5 cycles and the block returns to IDLE; rst=1 at byte 6 -> tx_valid_o = 0 next cycle and frame_cnt_o unchanged.

Source files
------------

// File: rtl/isa_tx_sequencer.sv
// rtl/isa_tx_sequencer.sv - fetches captured bus entries and serialises them as checksummed UART frames
//
// Ports:
//   clk_rd, rst              : clock (rising edge) and synchronous active-high reset
//   enable                   : permits starting a new fetch from IDLE
//   isa_empty_i, isa_rd_en_o : capture FIFO empty flag and one-cycle read strobe
//   isa_valid_i, isa_addr_i, isa_data_i, isa_mask_i : capture FIFO output entry
//   tx_data_o, tx_valid_o, tx_ready_i : byte stream to the UART transmitter
//   busy_o                   : high whenever the sequencer is not idle
//   frame_cnt_o, drop_cnt_o  : wrapping counts of sent frames and dropped entries
//   err_timeout_o            : sticky flag, FIFO never delivered a fetched entry
module isa_tx_sequencer #(
    parameter int         GUARD_CYCLES   = 3,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter bit         DROP_ZERO_MASK = 1'b1
) (
    input  logic        clk_rd,
    input  logic        rst,
    input  logic        enable,
    input  logic        isa_empty_i,
    output logic        isa_rd_en_o,
    input  logic        isa_valid_i,
    input  logic [31:0] isa_addr_i,
    input  logic [31:0] isa_data_i,
    input  logic [3:0]  isa_mask_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        busy_o,
    output logic [15:0] frame_cnt_o,
    output logic [15:0] drop_cnt_o,
    output logic        err_timeout_o
);

    typedef enum logic [2:0] {IDLE, FETCH, WAIT_VLD, SEND, GUARD} state_t;

    localparam logic [3:0]  LAST_IDX   = 4'd10;
    localparam logic [15:0] GUARD_LAST = 16'(GUARD_CYCLES - 1);

    state_t      state;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [3:0]  mask_q;
    logic [3:0]  idx;
    logic [1:0]  wait_cnt;
    logic [15:0] guard_cnt;

    logic        uart_region;
    logic [7:0]  checksum;
    logic [3:0]  nxt_idx;
    logic [7:0]  nxt_byte;

    assign uart_region = (addr_q == 32'h4000_1000) || (addr_q[31:12] == 20'h40004);

    assign checksum = addr_q[31:24] ^ addr_q[23:16] ^ addr_q[15:8] ^ addr_q[7:0]
                    ^ data_q[31:24] ^ data_q[23:16] ^ data_q[15:8] ^ data_q[7:0]
                    ^ {4'h0, mask_q};

    assign nxt_idx = idx + 4'd1;

    // Byte to load into tx_data_o when the current byte is accepted; the
    // sync byte (index 0) is loaded directly when the frame starts.
    always_comb begin
        nxt_byte = 8'h00;
        case (nxt_idx)
            4'd1:    nxt_byte = addr_q[31:24];
            4'd2:    nxt_byte = addr_q[23:16];
            4'd3:    nxt_byte = addr_q[15:8];
            4'd4:    nxt_byte = addr_q[7:0];
            4'd5:    nxt_byte = data_q[31:24];
            4'd6:    nxt_byte = data_q[23:16];
            4'd7:    nxt_byte = data_q[15:8];
            4'd8:    nxt_byte = data_q[7:0];
            4'd9:    nxt_byte = {4'h0, mask_q};
            4'd10:   nxt_byte = checksum;
            default: nxt_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk_rd) begin
        if (rst) begin
            state         <= IDLE;
            isa_rd_en_o   <= 1'b0;
            tx_valid_o    <= 1'b0;
            tx_data_o     <= 8'h00;
            busy_o        <= 1'b0;
            frame_cnt_o   <= 16'h0000;
            drop_cnt_o    <= 16'h0000;
            err_timeout_o <= 1'b0;
            addr_q        <= 32'h0;
            data_q        <= 32'h0;
            mask_q        <= 4'h0;
            idx           <= 4'd0;
            wait_cnt      <= 2'd0;
            guard_cnt     <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable && !isa_empty_i) begin
                        state       <= FETCH;
                        isa_rd_en_o <= 1'b1;
                        busy_o      <= 1'b1;
                    end
                end
                FETCH: begin
                    isa_rd_en_o <= 1'b0;
                    wait_cnt    <= 2'd0;
                    state       <= WAIT_VLD;
                end
                WAIT_VLD: begin
                    if (isa_valid_i) begin
                        addr_q <= isa_addr_i;
                        data_q <= isa_data_i;
                        mask_q <= isa_mask_i;
                        // Drop decision uses the FIFO output directly so it
                        // takes effect in the same cycle the entry is latched.
                        if (DROP_ZERO_MASK && (isa_mask_i == 4'h0)) begin
                            drop_cnt_o <= drop_cnt_o + 16'd1;
                            state      <= IDLE;
                            busy_o     <= 1'b0;
                        end else begin
                            idx        <= 4'd0;
                            tx_data_o  <= SYNC_BYTE;
                            tx_valid_o <= 1'b1;
                            state      <= SEND;
                        end
                    end else if (wait_cnt == 2'd3) begin
                        err_timeout_o <= 1'b1;
                        state         <= IDLE;
                        busy_o        <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end
                SEND: begin
                    // tx_valid_o is always high in SEND, so ready alone marks acceptance.
                    if (tx_ready_i) begin
                        if (idx == LAST_IDX) begin
                            frame_cnt_o <= frame_cnt_o + 16'd1;
                            tx_valid_o  <= 1'b0;
                            tx_data_o   <= 8'h00;
                            if (uart_region && (GUARD_CYCLES > 0)) begin
                                guard_cnt <= 16'd0;
                                state     <= GUARD;
                            end else begin
                                state  <= IDLE;
                                busy_o <= 1'b0;
                            end
                        end else begin
                            idx       <= nxt_idx;
                            tx_data_o <= nxt_byte;
                        end
                    end
                end
                GUARD: begin
                    if (guard_cnt == GUARD_LAST) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end else begin
                        guard_cnt <= guard_cnt + 16'd1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_isa_tx_sequencer.sv
// tb/tb_isa_tx_sequencer.sv - scoreboard bench for isa_tx_sequencer
module tb_isa_tx_sequencer;

    logic        clk_rd = 1'b0;
    logic        rst;
    logic        enable;
    logic        isa_empty;
    logic        isa_rd_en;
    logic        isa_valid;
    logic [31:0] isa_addr;
    logic [31:0] isa_data;
    logic [3:0]  isa_mask;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic [15:0] frame_cnt;
    logic [15:0] drop_cnt;
    logic        err_timeout;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } entry_t;

    entry_t     fifo[$];
    logic [7:0] exp_q[$];

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int last_acc_cyc = 0;
    int last_gap = 0;
    int rd_cyc = 0;
    int err_cyc = 0;
    int acc_in_frame = 0;
    int gap_val;
    bit no_valid = 0;

    isa_tx_sequencer dut (
        .clk_rd        (clk_rd),
        .rst           (rst),
        .enable        (enable),
        .isa_empty_i   (isa_empty),
        .isa_rd_en_o   (isa_rd_en),
        .isa_valid_i   (isa_valid),
        .isa_addr_i    (isa_addr),
        .isa_data_i    (isa_data),
        .isa_mask_i    (isa_mask),
        .tx_data_o     (tx_data),
        .tx_valid_o    (tx_valid),
        .tx_ready_i    (tx_ready),
        .busy_o        (busy),
        .frame_cnt_o   (frame_cnt),
        .drop_cnt_o    (drop_cnt),
        .err_timeout_o (err_timeout)
    );

    always #5 clk_rd = ~clk_rd;

    initial forever begin
        @(posedge clk_rd);
        cyc = cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Reference frame: sync, address MSB first, data MSB first, mask, XOR of bytes 1..9.
    function automatic void push_frame(input entry_t e);
        logic [7:0] b[11];
        logic [7:0] x;
        b[0] = 8'hA5;
        for (int i = 0; i < 4; i++) begin
            b[1 + i] = e.addr[31 - 8*i -: 8];
            b[5 + i] = e.data[31 - 8*i -: 8];
        end
        b[9] = {4'h0, e.mask};
        x = 8'h00;
        for (int i = 1; i <= 9; i++) x = x ^ b[i];
        b[10] = x;
        for (int i = 0; i < 11; i++) exp_q.push_back(b[i]);
    endfunction

    // Capture FIFO model: valid is presented the cycle after the read strobe.
    initial begin
        entry_t cur;
        bit     pending = 0;
        isa_valid = 1'b0;
        isa_addr  = 32'h0;
        isa_data  = 32'h0;
        isa_mask  = 4'h0;
        isa_empty = 1'b1;
        forever begin
            @(negedge clk_rd);
            isa_valid = 1'b0;
            if (pending) begin
                isa_valid = 1'b1;
                isa_addr  = cur.addr;
                isa_data  = cur.data;
                isa_mask  = cur.mask;
                pending   = 0;
            end
            if (isa_rd_en) begin
                rd_cyc   = cyc;
                last_gap = cyc - last_acc_cyc;
                if (fifo.size() > 0) begin
                    cur = fifo.pop_front();
                    if (!no_valid) begin
                        pending = 1;
                        if (cur.mask != 4'h0) push_frame(cur);
                    end
                end
            end
            isa_empty = (fifo.size() == 0);
        end
    end

    // Output monitor: scoreboard pop on every accepted byte, plus hold and no-bubble checks.
    initial begin
        logic       prev_valid = 1'b0;
        logic       prev_ready = 1'b0;
        logic [7:0] prev_data = 8'h00;
        logic [7:0] e;
        forever begin
            @(negedge clk_rd);
            if (rst) begin
                acc_in_frame = 0;
                exp_q.delete();
            end else begin
                if (prev_valid && !prev_ready && tx_valid) chk("hold", tx_data, prev_data);
                if (acc_in_frame != 0) chk("mid_valid", tx_valid, 1);
                if (tx_valid && tx_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_byte", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("byte", tx_data, e);
                    end
                    acc_in_frame = acc_in_frame + 1;
                    if (acc_in_frame == 11) begin
                        acc_in_frame = 0;
                        last_acc_cyc = cyc;
                    end
                end
            end
            prev_valid = tx_valid;
            prev_ready = tx_ready;
            prev_data  = tx_data;
        end
    end

    task automatic step();
        @(posedge clk_rd);
        #1;
    endtask

    task automatic wait_frames(input int target, input string tag);
        for (int i = 0; i < 400 && frame_cnt < target; i++) step();
        chk(tag, frame_cnt, target);
    endtask

    task automatic wait_byte(input int k, input string tag);
        for (int i = 0; i < 100 && !(tx_valid && acc_in_frame == k); i++) step();
        chk(tag, tx_valid && acc_in_frame == k, 1);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 100 && busy; i++) step();
        chk(tag, busy, 0);
    endtask

    initial begin
        rst      = 1'b1;
        enable   = 1'b1;
        tx_ready = 1'b1;
        repeat (3) step();
        chk("rst_rd_en", isa_rd_en, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        chk("rst_err", err_timeout, 0);
        rst = 1'b0;

        // Basic fetch and frame, ready held high.
        fifo.push_back('{32'h0000_1000, 32'h1234_5678, 4'hF});
        wait_frames(1, "frame1_cnt");
        chk("frame1_queue_drained", exp_q.size(), 0);

        // Backpressure at byte 4 for 5 cycles.
        fifo.push_back('{32'h0000_1000, 32'h1234_5678, 4'hF});
        wait_byte(4, "bp_reach");
        tx_ready = 1'b0;
        repeat (5) begin
            step();
            chk("bp_hold", tx_data, 8'h00);
        end
        tx_ready = 1'b1;
        wait_frames(2, "frame2_cnt");

        // Zero-mask entry dropped.
        fifo.push_back('{32'h0000_2000, 32'hDEAD_BEEF, 4'h0});
        for (int i = 0; i < 50 && drop_cnt != 16'd1; i++) step();
        chk("drop_cnt", drop_cnt, 1);
        wait_idle("drop_idle");
        chk("drop_frame_cnt", frame_cnt, 2);

        // Guard gap after a UART-region frame versus a normal frame.
        fifo.push_back('{32'h4000_4010, 32'hCAFE_F00D, 4'h5});
        fifo.push_back('{32'h0000_3000, 32'h0000_0000, 4'h1});
        wait_frames(4, "guard_frames");
        gap_val = last_gap;
        fifo.push_back('{32'h0000_5000, 32'h0102_0304, 4'h2});
        fifo.push_back('{32'h0000_6000, 32'hA0B0_C0D0, 4'h3});
        wait_frames(6, "normal_frames");
        chk("gap_normal", last_gap, 2);
        chk("gap_guard_extra", gap_val - last_gap, 3);
        fifo.push_back('{32'h4000_1000, 32'h5555_AAAA, 4'h8});
        fifo.push_back('{32'h0000_7000, 32'h0F0F_0F0F, 4'hC});
        wait_frames(8, "uart_exact_frames");
        chk("gap_uart_exact", last_gap, 5);
        wait_idle("guard_idle");

        // Fetch timeout: FIFO never presents valid.
        no_valid = 1;
        fifo.push_back('{32'h0000_8000, 32'h0000_0001, 4'h1});
        for (int i = 0; i < 30 && !err_timeout; i++) step();
        err_cyc = cyc;
        no_valid = 0;
        chk("timeout_err", err_timeout, 1);
        chk("timeout_latency", (err_cyc - rd_cyc) <= 5, 1);
        wait_idle("timeout_idle");

        // Reset while byte 6 is on the wire.
        fifo.push_back('{32'h0000_9000, 32'h1122_3344, 4'hA});
        wait_byte(6, "rst_reach");
        chk("err_sticky", err_timeout, 1);
        rst      = 1'b1;
        tx_ready = 1'b0;
        step();
        chk("midrst_tx_valid", tx_valid, 0);
        chk("midrst_frame_cnt", frame_cnt, 0);
        chk("midrst_err", err_timeout, 0);
        chk("midrst_busy", busy, 0);
        rst      = 1'b0;
        tx_ready = 1'b1;
        repeat (20) step();
        chk("post_rst_tx_valid", tx_valid, 0);
        chk("post_rst_frame_cnt", frame_cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
